// File: rtl/multi_channel_watchdog_pkg.sv
// ============================================================================
//  Module   : multi_channel_watchdog_pkg
//  Brief    : Shared state encoding and elaboration helpers for the watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package multi_channel_watchdog_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_FAULT   = 2'd3
    } wdt_state_t;

    // Prescaler counter width; a single bit still exists when PRESCALE is 1.
    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

    function automatic bit params_ok(input int channels, input int timeout,
                                     input int warn_at, input int window_min,
                                     input int prescale);
        return (channels >= 1) && (channels <= 16) && (warn_at < timeout) &&
               (window_min <= warn_at) && (prescale >= 1) && (window_min >= 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_channel_watchdog_wdt_channel.sv
// ============================================================================
//  Module   : wdt_channel
//  Brief    : One watchdog channel: state, saturating counter, sticky flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wdt_channel
    import multi_channel_watchdog_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 150000000,
    parameter int WARN_AT    = 120000000,
    parameter int WINDOW_MIN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    input  logic kick,
    input  logic clr,
    output logic warn,
    output logic timeout,
    output logic early
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_WARN_AT = CNT_W'(WARN_AT);

    wdt_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_warn;
    logic             r_timeout;
    logic             r_early;

    logic [CNT_W-1:0] w_count_inc;
    logic             w_too_early;

    assign w_count_inc = r_count + CNT_W'(1);

    // With the window disabled every kick is legal, so no compare is built.
    if (WINDOW_MIN == 0) begin : g_no_window
        assign w_too_early = 1'b0;
    end else begin : g_window
        localparam logic [CNT_W-1:0] c_WINDOW_MIN = CNT_W'(WINDOW_MIN);
        assign w_too_early = (r_count < c_WINDOW_MIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_warn    <= 1'b0;
            r_timeout <= 1'b0;
            r_early   <= 1'b0;
        end else if (!enable) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_warn    <= 1'b0;
            r_timeout <= 1'b0;
            r_early   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_COUNT;
                    r_count <= '0;
                end
                ST_COUNT: begin
                    // clr has nothing to clear here, so kick and tick still act.
                    if (kick) begin
                        if (w_too_early) begin
                            r_state <= ST_FAULT;
                            r_early <= 1'b1;
                        end else begin
                            r_count <= '0;
                            r_warn  <= 1'b0;
                        end
                    end else if (tick) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == c_TIMEOUT) begin
                            r_state   <= ST_EXPIRED;
                            r_timeout <= 1'b1;
                            r_warn    <= 1'b0;
                        end else if (w_count_inc >= c_WARN_AT) begin
                            r_warn <= 1'b1;
                        end
                    end
                end
                ST_EXPIRED, ST_FAULT: begin
                    if (clr) begin
                        r_state   <= ST_COUNT;
                        r_count   <= '0;
                        r_warn    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_early   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign warn    = r_warn;
    assign timeout = r_timeout;
    assign early   = r_early;

endmodule

`default_nettype wire

// File: rtl/multi_channel_watchdog.sv
// ============================================================================
//  Module   : multi_channel_watchdog
//  Brief    : N-channel windowed watchdog with shared prescaler and irq OR.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multi_channel_watchdog
    import multi_channel_watchdog_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 150000000,
    parameter int WARN_AT    = 120000000,
    parameter int WINDOW_MIN = 0,
    parameter int PRESCALE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] kick,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] warn,
    output logic [CHANNELS-1:0] timeout,
    output logic [CHANNELS-1:0] early,
    output logic                irq
);

    localparam int c_PRE_W = pre_width(PRESCALE);

    if (!params_ok(CHANNELS, TIMEOUT, WARN_AT, WINDOW_MIN, PRESCALE)) begin : g_bad_params
        $error("multi_channel_watchdog: illegal parameter combination");
    end

    logic w_tick;

    if (PRESCALE == 1) begin : g_pre_bypass
        assign w_tick = 1'b1;
    end else begin : g_pre
        localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
        logic [c_PRE_W-1:0] r_pre;

        // Free-running; kicks never realign the tick phase.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pre <= '0;
            end else if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end

        assign w_tick = (r_pre == c_PRE_LAST);
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        wdt_channel #(
            .CNT_W      (CNT_W),
            .TIMEOUT    (TIMEOUT),
            .WARN_AT    (WARN_AT),
            .WINDOW_MIN (WINDOW_MIN)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (w_tick),
            .enable  (enable[gi]),
            .kick    (kick[gi]),
            .clr     (clr[gi]),
            .warn    (warn[gi]),
            .timeout (timeout[gi]),
            .early   (early[gi])
        );
    end

    assign irq = (|timeout) | (|early);

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_watchdog.sv
// ============================================================================
//  Module   : tb_multi_channel_watchdog
//  Brief    : Directed scoreboard bench for the multi-channel watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_watchdog;

    logic       r_clk;
    logic       r_rst;
    logic [1:0] r_enable, r_kick, r_clr;
    logic [1:0] w_warn, w_timeout, w_early;
    logic       w_irq;

    logic [1:0] r_enable4, r_kick4, r_clr4;
    logic [1:0] w_warn4, w_timeout4, w_early4;
    logic       w_irq4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [6:0] vec;   // {warn, timeout, early, irq}
    } exp_t;

    exp_t q_exp[$];

    multi_channel_watchdog #(
        .CHANNELS(2), .CNT_W(8), .TIMEOUT(10), .WARN_AT(7),
        .WINDOW_MIN(3), .PRESCALE(1)
    ) dut (
        .clk(r_clk), .rst(r_rst), .enable(r_enable), .kick(r_kick), .clr(r_clr),
        .warn(w_warn), .timeout(w_timeout), .early(w_early), .irq(w_irq)
    );

    multi_channel_watchdog #(
        .CHANNELS(2), .CNT_W(8), .TIMEOUT(10), .WARN_AT(7),
        .WINDOW_MIN(3), .PRESCALE(4)
    ) dut4 (
        .clk(r_clk), .rst(r_rst), .enable(r_enable4), .kick(r_kick4), .clr(r_clr4),
        .warn(w_warn4), .timeout(w_timeout4), .early(w_early4), .irq(w_irq4)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] w, input logic [1:0] t,
                            input logic [1:0] e, input logic i);
        exp_t x;
        x.tag = tag;
        x.vec = {w, t, e, i};
        q_exp.push_back(x);
    endtask

    task automatic check_next();
        exp_t       x;
        logic [6:0] obs;
        x   = q_exp.pop_front();
        obs = {w_warn, w_timeout, w_early, w_irq};
        n_checks++;
        assert (obs === x.vec) else begin
            n_errors++;
            $error("FAIL %s observed={w,t,e,irq}=%b expected=%b", x.tag, obs, x.vec);
        end
    endtask

    task automatic step(input int n, input string tag, input logic [1:0] w,
                        input logic [1:0] t, input logic [1:0] e, input logic i);
        push_exp(tag, w, t, e, i);
        cyc(n);
        check_next();
    endtask

    initial begin
        int  edges;
        bit  seen;
        r_rst = 1'b1;
        r_enable = 2'b00; r_kick = 2'b00; r_clr = 2'b00;
        r_enable4 = 2'b00; r_kick4 = 2'b00; r_clr4 = 2'b00;
        push_exp("reset", 2'b00, 2'b00, 2'b00, 1'b0);
        #1;
        check_next();
        cyc(2);
        r_rst = 1'b0;

        // Unkicked channel 0 runs to expiry; channel 1 stays quiet.
        r_enable = 2'b01;
        step(1,  "t1_enter",      2'b00, 2'b00, 2'b00, 1'b0);
        step(6,  "t1_cnt6",       2'b00, 2'b00, 2'b00, 1'b0);
        step(1,  "t1_warn",       2'b01, 2'b00, 2'b00, 1'b0);
        step(2,  "t1_cnt9",       2'b01, 2'b00, 2'b00, 1'b0);
        step(1,  "t1_timeout",    2'b00, 2'b01, 2'b00, 1'b1);
        step(30, "t1_hold",       2'b00, 2'b01, 2'b00, 1'b1);
        r_kick = 2'b01;
        step(1,  "t1_kick_ignored", 2'b00, 2'b01, 2'b00, 1'b1);
        r_kick = 2'b00;
        r_enable = 2'b00;
        step(1,  "t1_disable",    2'b00, 2'b00, 2'b00, 1'b0);

        // Regular legal kicks every 5 cycles keep everything low.
        r_enable = 2'b01;
        step(1, "t2_enter", 2'b00, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(4);
            r_kick = 2'b01;
            step(1, "t2_kick", 2'b00, 2'b00, 2'b00, 1'b0);
            r_kick = 2'b00;
        end

        // Kick at count=1 is inside the forbidden window.
        cyc(1);
        r_kick = 2'b01;
        step(1,  "t3_early",      2'b00, 2'b00, 2'b01, 1'b1);
        r_kick = 2'b00;
        step(15, "t3_frozen",     2'b00, 2'b00, 2'b01, 1'b1);
        r_clr = 2'b01;
        step(1,  "t3_clr",        2'b00, 2'b00, 2'b00, 1'b0);
        r_clr = 2'b00;
        step(9,  "t3_cnt9",       2'b01, 2'b00, 2'b00, 1'b0);
        step(1,  "t3_timeout",    2'b00, 2'b01, 2'b00, 1'b1);

        // clr beats kick in EXPIRED; kick beats the terminal tick.
        r_clr = 2'b01; r_kick = 2'b01;
        step(1, "t4_clr_beats_kick", 2'b00, 2'b00, 2'b00, 1'b0);
        r_clr = 2'b00; r_kick = 2'b00;
        step(9, "t4_cnt9",        2'b01, 2'b00, 2'b00, 1'b0);
        r_kick = 2'b01;
        step(1, "t4_kick_terminal", 2'b00, 2'b00, 2'b00, 1'b0);
        r_kick = 2'b00;
        step(6, "t4_cnt6",        2'b00, 2'b00, 2'b00, 1'b0);
        step(1, "t4_cnt7",        2'b01, 2'b00, 2'b00, 1'b0);
        r_clr = 2'b01;
        step(1, "t4_clr_in_count", 2'b01, 2'b00, 2'b00, 1'b0);
        r_clr = 2'b00;

        // Asynchronous reset at count=8 with warn high.
        #1 r_rst = 1'b1;
        push_exp("t5_async_rst", 2'b00, 2'b00, 2'b00, 1'b0);
        #1;
        check_next();
        cyc(2);
        r_rst = 1'b0;
        step(1, "t5_restart",     2'b00, 2'b00, 2'b00, 1'b0);
        step(6, "t5_cnt6",        2'b00, 2'b00, 2'b00, 1'b0);
        step(1, "t5_warn",        2'b01, 2'b00, 2'b00, 1'b0);
        r_enable = 2'b00;
        step(1, "t5_idle",        2'b00, 2'b00, 2'b00, 1'b0);

        // Channel independence.
        r_enable = 2'b11;
        step(2, "t6_both_count",  2'b00, 2'b00, 2'b00, 1'b0);
        r_kick = 2'b10;
        step(1, "t6_ch1_early",   2'b00, 2'b00, 2'b10, 1'b1);
        r_kick = 2'b00;
        r_clr = 2'b01;
        step(1, "t6_clr_ch0_noop", 2'b00, 2'b00, 2'b10, 1'b1);
        r_clr = 2'b00;
        step(4, "t6_ch0_warn",    2'b01, 2'b00, 2'b10, 1'b1);
        r_clr = 2'b10;
        step(1, "t6_clr_ch1",     2'b01, 2'b00, 2'b00, 1'b0);
        r_clr = 2'b00;
        r_enable = 2'b00;
        step(1, "t6_idle",        2'b00, 2'b00, 2'b00, 1'b0);

        // PRESCALE=4: expiry about 40 clocks after enable.
        r_enable4 = 2'b01;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 80) begin
            cyc(1);
            edges++;
            if (w_timeout4[0]) seen = 1'b1;
        end
        n_checks++;
        assert (seen === 1'b1 && edges >= 37 && edges <= 43) else begin
            n_errors++;
            $error("FAIL t7_prescale_timeout observed_edges=%0d seen=%0b expected=37..43", edges, seen);
        end
        n_checks++;
        assert ({w_warn4, w_early4, w_irq4} === 5'b00001) else begin
            n_errors++;
            $error("FAIL t7_prescale_flags observed=%b expected=00001",
                   {w_warn4, w_early4, w_irq4});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
